// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder controller built around one 1-bit full adder
// Adds a + b + cin one bit per clock, LSB first, and reports the result with a done pulse.

module full_adder (
   input  logic a_i,
   input  logic b_i,
   input  logic ci_i,
   output logic s_o,
   output logic co_o
);
   assign s_o  = a_i ^ b_i ^ ci_i;
   assign co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);
endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] sa_q;
   logic [WIDTH-1:0] sb_q;
   logic [WIDTH-1:0] sr_q;
   logic             c_q;
   logic [CW-1:0]    n_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;

   logic             fa_s;
   logic             fa_co;
   logic [WIDTH:0]   sr_cat;
   logic [WIDTH-1:0] sr_d;

   full_adder u_fa (
      .a_i  (sa_q[0]),
      .b_i  (sb_q[0]),
      .ci_i (c_q),
      .s_o  (fa_s),
      .co_o (fa_co)
   );

   // Concatenate-then-shift keeps the MSB insertion legal even when WIDTH is 1.
   assign sr_cat = {fa_s, sr_q} >> 1;
   assign sr_d   = sr_cat[WIDTH-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         sr_q    <= '0;
         c_q     <= 1'b0;
         n_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  sa_q    <= a;
                  sb_q    <= b;
                  c_q     <= cin;
                  n_q     <= '0;
                  sr_q    <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               sa_q <= sa_q >> 1;
               sb_q <= sb_q >> 1;
               sr_q <= sr_d;
               c_q  <= fa_co;
               n_q  <= n_q + CW'(1);
               if (n_q == LAST_BIT) begin
                  sum_q   <= sr_d;
                  cout_q  <= fa_co;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
endmodule
